// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   FETCH_ADDR_W / FETCH_DATA_W : default PC/address and instruction widths
//   FETCH_RESET_PC              : default PC loaded on reset
//   fetch_entry_t               : one buffered instruction with its PC
//   occ_width()                 : width needed to hold an occupancy of 0..depth
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_DATA_W-1:0] ir;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // One extra bit so a completely full FIFO (count == depth) is representable.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push/wdata : write an entry this cycle
//   pop        : retire the head entry this cycle (ignored when empty)
//   flush      : discard everything at the next edge; overrides push and pop
//   rdata      : head entry (registered storage, valid when !empty)
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = occ_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       wdata,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       rdata,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign rdata  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before anything
  // has ever been written; a flush only rewinds the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the single-cycle core.
// Owns the PC, issues word-addressed requests to instruction memory (data
// returns exactly one cycle later), buffers {ir, pc} in a prefetch FIFO and
// hands instructions downstream over valid/ready. A redirect flushes all
// buffered and in-flight instructions and restarts fetch at redirect_pc.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_req, imem_addr         : fetch request and its word address
//   imem_rdata                  : instruction for last cycle's request
//   redirect_valid, redirect_pc : branch/jump redirect
//   out_valid, out_ready        : downstream handshake
//   out_ir, out_pc              : instruction and its address
// Build option FETCH_BYPASS_EN: when the FIFO is empty an arriving response is
// presented combinationally in its arrival cycle (latency 1 instead of 2) and
// is not written to the FIFO if it is accepted in that same cycle.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       DATA_W   = FETCH_DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_ir,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = occ_width(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              arrive;
  logic              push;
  logic              pop;
  logic [SUM_W-1:0]  credit_used;
  fetch_entry_t      wdata;
  fetch_entry_t      head;

  // A request is only issued when its response is guaranteed a FIFO slot:
  // buffered entries plus the one possibly in flight must leave room.
  // rst_n gates the request so it drops the moment reset is asserted.
  assign credit_used = SUM_W'(count) + SUM_W'(inflight);
  assign imem_req    = rst_n && !redirect_valid && (credit_used < SUM_W'(DEPTH));
  assign imem_addr   = fpc;

  // Memory latency is exactly one cycle, so the only response that can be
  // killed is the one arriving in the redirect cycle itself; gating the
  // arrival with redirect_valid discards it.
  assign arrive = inflight && !redirect_valid;
  assign wdata  = '{ir: imem_rdata, pc: inflight_pc};

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass    = empty && arrive;
  assign push      = arrive && !(bypass && out_ready);
  assign out_valid = !empty || bypass;
  assign out_ir    = bypass ? imem_rdata : head.ir;
  assign out_pc    = bypass ? inflight_pc : head.pc;
`else
  assign push      = arrive;
  assign out_valid = !empty;
  assign out_ir    = head.ir;
  assign out_pc    = head.pc;
`endif

  // A consumed bypass instruction never entered the FIFO, so only pop when
  // the FIFO is actually supplying the head.
  assign pop = out_valid && out_ready && !empty;

  // PC and in-flight tracking. A redirect wins over any request and cancels
  // the outstanding response; the next request goes to redirect_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc         <= redirect_pc;
      inflight    <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fpc;
        fpc         <= fpc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The credit rule must make a push into a full FIFO impossible unless the
  // head leaves in the same cycle.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                !(push && full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A small instruction memory answers every request one cycle later with
// addr ^ 32'hA5A5_0000. A queue-based model of the fetch stage predicts the
// outputs every cycle; directed sequences add literal expectations.
// Honours FETCH_BYPASS_EN in the same way as the design.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;

  int compared   = 0;
  int mismatched = 0;
  int req_count  = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ir         (out_ir),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency, garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] ir;
    logic [31:0] pc;
    bit          from_bypass;
  } exp_t;

  ent_t        model_q[$];
  logic [31:0] model_fpc       = 32'h0;
  logic [31:0] model_flight_pc = 32'h0;
  bit          model_flight    = 1'b0;
  exp_t        upd;
  exp_t        cmp;
  ent_t        new_ent;
  logic [31:0] delivered[$];

  function automatic exp_t predict();
    exp_t e;
    e.req         = ((model_q.size() + int'(model_flight)) < DEPTH) && !redirect_valid;
    e.addr        = model_fpc;
    e.valid       = (model_q.size() != 0);
    e.ir          = 32'h0;
    e.pc          = 32'h0;
    e.from_bypass = 1'b0;
    if (e.valid) begin
      e.ir = model_q[0].ir;
      e.pc = model_q[0].pc;
    end
`ifdef FETCH_BYPASS_EN
    else if (model_flight && !redirect_valid) begin
      e.valid       = 1'b1;
      e.from_bypass = 1'b1;
      e.pc          = model_flight_pc;
      e.ir          = model_flight_pc ^ KEY;
    end
`endif
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      model_fpc       = 32'h0;
      model_flight    = 1'b0;
      model_flight_pc = 32'h0;
    end else begin
      upd = predict();
      if (redirect_valid) begin
        model_q.delete();
        model_fpc    = redirect_pc;
        model_flight = 1'b0;
      end else begin
        if (upd.valid && out_ready && !upd.from_bypass) begin
          void'(model_q.pop_front());
        end
        if (model_flight && !(upd.from_bypass && out_ready)) begin
          new_ent.ir = model_flight_pc ^ KEY;
          new_ent.pc = model_flight_pc;
          model_q.push_back(new_ent);
        end
        model_flight = upd.req;
        if (upd.req) begin
          model_flight_pc = model_fpc;
          model_fpc       = model_fpc + 32'd1;
        end
      end
    end
  end

  // Record every instruction the DUT hands downstream, and every request.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) delivered.push_back(out_pc);
    if (rst_n && imem_req) req_count++;
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkLog(input string name, input int idx, input logic [31:0] expected);
    if (delivered.size() > idx) begin
      checkOutput(name, delivered[idx], expected);
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: only %0d delivered, expected entry %0d = 0x%08h",
               name, delivered.size(), idx, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp = predict();
      checkOutput("imem_req", 32'(imem_req), 32'(cmp.req));
      checkOutput("imem_addr", imem_addr, cmp.addr);
      checkOutput("out_valid", 32'(out_valid), 32'(cmp.valid));
      if (cmp.valid) begin
        checkOutput("out_ir", out_ir, cmp.ir);
        checkOutput("out_pc", out_pc, cmp.pc);
      end
    end
  end

  task automatic applyStimulus(input bit ready, input bit rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    out_ready      = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- directed sequences ----------------
  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_ir", out_ir, 32'h0);
    checkOutput("rst_out_pc", out_pc, 32'h0);

    // Streaming from RESET_PC with out_ready held high
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1_c0_req", 32'(imem_req), 32'd1);
    checkOutput("t1_c0_addr", imem_addr, 32'h0);
    checkOutput("t1_c0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_c1_addr", imem_addr, 32'h1);
`ifdef FETCH_BYPASS_EN
    checkOutput("t1_c1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_c1_pc", out_pc, 32'h0);
`else
    checkOutput("t1_c1_valid", 32'(out_valid), 32'd0);
`endif
    @(negedge clk);
    checkOutput("t1_c2_valid", 32'(out_valid), 32'd1);
`ifdef FETCH_BYPASS_EN
    checkOutput("t1_c2_pc", out_pc, 32'h1);
    checkOutput("t1_c2_ir", out_ir, 32'hA5A5_0001);
`else
    checkOutput("t1_c2_pc", out_pc, 32'h0);
    checkOutput("t1_c2_ir", out_ir, 32'hA5A5_0000);
`endif
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    checkLog("t1_seq0", 0, 32'h0);
    checkLog("t1_seq1", 1, 32'h1);
    checkLog("t1_seq2", 2, 32'h2);

    // Stall: restart at 0 with out_ready low for 10 cycles
    applyStimulus(1'b0, 1'b1, 32'h0);
    req_count = 0;
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t2_req_count", 32'(req_count), 32'd4);
    checkOutput("t2_req_off", 32'(imem_req), 32'd0);
    checkOutput("t2_head_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_head_pc", out_pc, 32'h0);
    checkOutput("t2_head_ir", out_ir, 32'hA5A5_0000);
    delivered.delete();
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) checkLog("t2_resume", i, 32'(i));

    // Redirect to 0x100 with three entries buffered and one in flight
    applyStimulus(1'b0, 1'b1, 32'h0);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("t3_redir_req", 32'(imem_req), 32'd0);
    checkOutput("t3_pre_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t3_flushed_valid", 32'(out_valid), 32'd0);
    checkOutput("t3_new_addr", imem_addr, 32'h100);
    checkOutput("t3_new_req", 32'(imem_req), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t3_head_valid", 32'(out_valid), 32'd1);
    checkOutput("t3_head_pc", out_pc, 32'h100);
    checkOutput("t3_head_ir", out_ir, 32'hA5A5_0100);
    delivered.delete();
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    checkLog("t3_seq0", 0, 32'h100);
    checkLog("t3_seq1", 1, 32'h101);

    // Back-to-back redirects: 0x20 then 0x40, the second wins
    applyStimulus(1'b1, 1'b1, 32'h20);
    applyStimulus(1'b1, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t4_addr", imem_addr, 32'h40);
    checkOutput("t4_valid", 32'(out_valid), 32'd0);
    delivered.delete();
    repeat (5) applyStimulus(1'b1, 1'b0, 32'h0);
    checkLog("t4_first", 0, 32'h40);
    checkLog("t4_second", 1, 32'h41);

    // PC wrap-around at the top of the address space
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    delivered.delete();
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    checkLog("t5_wrap0", 0, 32'hFFFF_FFFE);
    checkLog("t5_wrap1", 1, 32'hFFFF_FFFF);
    checkLog("t5_wrap2", 2, 32'h0000_0000);
    checkLog("t5_wrap3", 3, 32'h0000_0001);

    // Asynchronous reset with a full FIFO
    applyStimulus(1'b0, 1'b1, 32'h0);
    repeat (7) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("t6_full_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_full_req", 32'(imem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_async_req", 32'(imem_req), 32'd0);
    checkOutput("t6_async_addr", imem_addr, 32'h0);
    delivered.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t6_restart_req", 32'(imem_req), 32'd1);
    checkOutput("t6_restart_addr", imem_addr, 32'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    checkLog("t6_seq0", 0, 32'h0);
    checkLog("t6_seq1", 1, 32'h1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
